// File: rtl/pmem_arbiter.sv
// Arbitrates the shared cacheline adapter between the demand cache and the prefetcher.
// Demand has priority, a bounded-wait counter stops prefetch starvation, and matching demand reads merge into an in-flight prefetch.
module pmem_arbiter #(
  parameter int unsigned PF_MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dc_read,
  input  logic         dc_write,
  input  logic [31:0]  dc_address,
  input  logic [255:0] dc_wdata,
  output logic [255:0] dc_rdata,
  output logic         dc_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 5;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned CNT_W  = (PF_MAX_WAIT == 0) ? 1 : $clog2(PF_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PF_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               merge_q, merge_d;
  logic [TAG_W-1:0]   line_q, line_d;
  logic               pmem_read_q, pmem_read_d;
  logic               pmem_write_q, pmem_write_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  result_q, result_d;
  logic               dc_resp_q, dc_resp_d;
  logic               pf_resp_q, pf_resp_d;

  logic pf_force;
  logic dc_req;
  logic merge_hit;
  logic unused_offsets;

  assign dc_req    = dc_read | dc_write;
  assign pf_force  = pf_read && (PF_MAX_WAIT != 0) && (wait_cnt_q == CNT_MAX);
  assign merge_hit = dc_read && (dc_address[ADDR_W-1:OFF_W] == line_q);
  // Byte offsets within a line never reach the adapter.
  assign unused_offsets = ^{dc_address[OFF_W-1:0], pf_address[OFF_W-1:0]};

  // Next-state, grant, wait counter and registered output values.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    merge_d      = merge_q;
    line_d       = line_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    wdata_d      = wdata_q;
    result_d     = result_q;
    dc_resp_d    = 1'b0;
    pf_resp_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pf_force || (!dc_req && pf_read)) begin
          state_d     = PREFETCH;
          pmem_read_d = 1'b1;
          line_d      = pf_address[ADDR_W-1:OFF_W];
          wait_cnt_d  = '0;
        end else if (dc_req) begin
          state_d      = DEMAND;
          pmem_read_d  = ~dc_write;
          pmem_write_d = dc_write;
          line_d       = dc_address[ADDR_W-1:OFF_W];
          if (dc_write) begin
            wdata_d = dc_wdata;
          end
          if (pf_read && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      DEMAND: begin
        if (pmem_resp) begin
          state_d      = DONE;
          result_d     = pmem_rdata;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          dc_resp_d    = 1'b1;
        end
      end
      PREFETCH: begin
        if (merge_hit) begin
          merge_d = 1'b1;
        end
        if (pmem_resp) begin
          state_d     = DONE;
          result_d    = pmem_rdata;
          pmem_read_d = 1'b0;
          pf_resp_d   = 1'b1;
          dc_resp_d   = merge_q | merge_hit;
        end
      end
      DONE: begin
        merge_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!pf_read) begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      merge_q      <= 1'b0;
      line_q       <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      wdata_q      <= '0;
      result_q     <= '0;
      dc_resp_q    <= 1'b0;
      pf_resp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      merge_q      <= merge_d;
      line_q       <= line_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      wdata_q      <= wdata_d;
      result_q     <= result_d;
      dc_resp_q    <= dc_resp_d;
      pf_resp_q    <= pf_resp_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = {line_q, OFF_W'(0)};
  assign pmem_wdata   = wdata_q;
  assign dc_resp      = dc_resp_q;
  assign pf_resp      = pf_resp_q;
  assign dc_rdata     = result_q;
  assign pf_rdata     = result_q;

endmodule
